mem_responder: RTL

Memory-side responder for the matrix processor's shared memory bus. Decodes the processor's active-low chip selects, write enable and 7-bit address. Serves a read/write RAM bank on `dinx` and a read-only weight ROM bank on `dinw`, both with one-cycle registered read latency. A host load port initialises both banks before the processor runs.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the matrix processor's shared bus.
//               A read/write RAM bank drives dinx and a read-only weight ROM
//               bank drives dinw, each with one-cycle registered read latency.
//               A host load port fills both banks while in LOAD; the last
//               load word hands the bus over to the processor (RUN).
// Ports       : clk, rst (async, active-low)
//               csb[1:0] (bit0 RAM, bit1 ROM, active-low), web, addr, din
//               dinx, dinw          registered read data
//               ld_valid/ld_ready/ld_sel/ld_addr/ld_data/ld_last  load port
//               run, err (sticky out-of-range), wr_count (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 128,
    parameter int ROM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            csb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dinx,
    output logic [DATA_WIDTH-1:0] dinw,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_sel,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  run,
    output logic                  err,
    output logic [7:0]            wr_count
);

    localparam int unsigned WORDS = 1 << ADDR_WIDTH;
    // Depth limits one bit wider than the address so a full-range depth fits.
    localparam logic [ADDR_WIDTH:0] RAM_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ROM_LIM = (ADDR_WIDTH + 1)'(ROM_DEPTH);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   dinx_q, dinx_d;
    logic [DATA_WIDTH-1:0]   dinw_q, dinw_d;
    logic                    err_q, err_d;
    logic [7:0]              wr_count_q, wr_count_d;

    logic [DATA_WIDTH-1:0]   ram_q [WORDS];
    logic [DATA_WIDTH-1:0]   rom_q [WORDS];

    logic                    in_run;
    logic                    load_fire;
    logic                    ram_sel, rom_sel;
    logic                    ram_ok, rom_ok, ld_ok;
    logic                    ram_we, rom_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    assign in_run    = (state_q == S_RUN);
    assign ld_ready  = (state_q == S_LOAD);
    assign load_fire = ld_valid & ld_ready;
    assign ram_sel   = in_run & ~csb[0];
    assign rom_sel   = in_run & ~csb[1];

    assign ram_ok = ({1'b0, addr} < RAM_LIM);
    assign rom_ok = ({1'b0, addr} < ROM_LIM);
    assign ld_ok  = ld_sel ? ({1'b0, ld_addr} < ROM_LIM)
                           : ({1'b0, ld_addr} < RAM_LIM);

    // Array writes are qualified by rst so that nothing is written on an edge
    // that coincides with (or falls inside) reset assertion.
    assign ram_we    = rst & ((load_fire & ~ld_sel & ld_ok) | (ram_sel & ~web & ram_ok));
    assign rom_we    = rst & load_fire & ld_sel & ld_ok;
    assign ram_waddr = in_run ? addr : ld_addr;
    assign ram_wdata = in_run ? din  : ld_data;

    always_comb begin
        state_d    = state_q;
        dinx_d     = dinx_q;
        dinw_d     = dinw_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;

        if (load_fire) begin
            if (!ld_ok) begin
                err_d = 1'b1;
            end
            if (ld_last) begin
                state_d = S_RUN;
            end
        end

        if (ram_sel) begin
            if (!ram_ok) begin
                err_d = 1'b1;
            end
            if (web) begin
                dinx_d = ram_ok ? ram_q[addr] : '0;
            end else if (ram_ok && (wr_count_q != 8'hFF)) begin
                wr_count_d = wr_count_q + 8'd1;
            end
        end

        if (rom_sel) begin
            if (!rom_ok) begin
                err_d = 1'b1;
            end
            dinw_d = rom_ok ? rom_q[addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            dinx_q     <= '0;
            dinw_q     <= '0;
            err_q      <= 1'b0;
            wr_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            dinx_q     <= dinx_d;
            dinw_q     <= dinw_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage is intentionally not reset: contents survive a reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
        if (rom_we) begin
            rom_q[ld_addr] <= ld_data;
        end
    end

    assign dinx     = dinx_q;
    assign dinw     = dinw_q;
    assign run      = in_run;
    assign err      = err_q;
    assign wr_count = wr_count_q;

endmodule
`default_nettype wire
